logic_axi4_lite_bus_route_scheduler: RTL and testbench
======================================================

Name: logic_axi4_lite_bus_route_scheduler

Overview:
Generates routing tokens (tid = slave index, tuser[0] = decode hit) for a multi-slave AXI4-Lite bus mux's five stream channels.
- Decodes write/read addresses against a per-slave base/mask table.
- Issues one token per address handshake to the address channel.
- Queues the same token in order for the data and response channels, limiting outstanding transactions.
- Sits between the bus slave port and the mux's routing inputs.

Parameters:
SLAVES, 1, number of downstream slaves
SLAVES_WIDTH, (SLAVES >= 2) ? $clog2(SLAVES) : 1, tid width
ADDRESS_WIDTH, 32, address width
OUTSTANDING, 4, per-direction queue depth (power of two, >= 2)
SLAVE_BASE, '0, packed [SLAVES-1:0][ADDRESS_WIDTH-1:0] base per slave
SLAVE_MASK, '0, packed [SLAVES-1:0][ADDRESS_WIDTH-1:0] compare mask per slave

Ports:
aclk  in  1  clock
areset_n  in  1  asynchronous active-low reset
wr_req_valid / wr_req_ready  in/out  1  write address request handshake
wr_req_addr  in  ADDRESS_WIDTH  write address (awaddr)
rd_req_valid / rd_req_ready  in/out  1  read address request handshake
rd_req_addr  in  ADDRESS_WIDTH  read address (araddr)
aw_tvalid, aw_tready, aw_tid, aw_thit  out,in,out,out  1,1,SLAVES_WIDTH,1  write-address route token
w_tvalid, w_tready, w_tid, w_thit  out,in,out,out  1,1,SLAVES_WIDTH,1  write-data route token
b_tvalid, b_tready, b_tid, b_thit  out,in,out,out  1,1,SLAVES_WIDTH,1  write-response route token
ar_tvalid, ar_tready, ar_tid, ar_thit  out,in,out,out  1,1,SLAVES_WIDTH,1  read-address route token
r_tvalid, r_tready, r_tid, r_thit  out,in,out,out  1,1,SLAVES_WIDTH,1  read-data route token

Behaviour:
- Reset: all *_tvalid = 0; queues empty; *_tid = 0; *_thit = 0. wr_req_ready and rd_req_ready are combinational and evaluate to 1 in reset.
- Decode (combinational):
  - hit[k] = ((addr & SLAVE_MASK[k]) == (SLAVE_BASE[k] & SLAVE_MASK[k])).
  - Lowest hitting k wins.
  - No hit: thit = 0, tid = 0 (DECERR path).
- Write acceptance: wr_req_ready = (!aw_tvalid || aw_tready) && !w_full && !b_full. On wr_req_valid && wr_req_ready, all three of the following happen:
  - aw token register loads {tid, hit} with 1-cycle latency;
  - token pushed to W queue;
  - token pushed to B queue.
- W and B queues: independent FIFOs of depth OUTSTANDING.
  - w_tvalid = !w_empty, b_tvalid = !b_empty; outputs show the FIFO head.
  - Pop on tvalid && tready.
  - Push and pop in the same cycle: occupancy unchanged, legal when full.
  - Pointers are SLAVES_WIDTH-independent, log2(OUTSTANDING)+1 bits with wrap bit; full = same index, differing wrap bit.
- B token ordering: the B token must not be popped before its W token. The B queue tracks a "data-done" count, incremented on W pop and decremented on B pop. b_tvalid = !b_empty && (done_count != 0 || (w_pop && same entry)); the same-cycle term is ignored, so b_tvalid requires done_count != 0 registered. Simultaneous increment and decrement leaves the count unchanged.
- Read path mirrors the write path: ar token register and R queue. rd_req_ready = (!ar_tvalid || ar_tready) && !r_full.
- aw/ar token registers: hold while tvalid && !tready; clear tvalid on tready without a new request.
- Reset mid-operation: all queued tokens are discarded; no partial state survives.

Optional Feature:
LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
- Defined: adds outputs decerr_wr_count [15:0] and decerr_rd_count [15:0]. Each is a saturating counter of accepted requests with hit = 0. Reset to 0; holds at 16'hFFFF.
- Undefined: ports and counters are absent.

Decomposition:
- Package logic_axi4_lite_bus_pkg holds:
  - route_token_t packed struct {hit, tid};
  - decode function (addr, base, mask table) -> route_token_t.
- Sub-module logic_axi4_lite_bus_route_fifo (parameters: depth, token width), instantiated three times for W, B and R. It provides push/pop/full/empty/head.

Test Plan:
- SLAVES=2, BASE={0x1000,0x0000}, MASK={0xF000,0xF000}. Write to 0x1004 -> next cycle aw_tvalid=1, aw_tid=1, aw_thit=1; then w_tid=1, then b_tid=1.
- Write to 0x8000 -> aw_thit=0, aw_tid=0; W/B tokens have thit=0; STATS_EN: decerr_wr_count = 1.
- OUTSTANDING=4. Issue 4 writes with w_tready=0 -> wr_req_ready=0 after the 4th. Pulse one w_tready -> ready returns 1 only after the B pop as well.
- b_tready held at 1 with w_tready=0 -> b_tvalid stays 0. W pop -> b_tvalid=1 the next cycle with the matching tid.
- Concurrent reads to slaves 0,1,0 with r_tready random -> r_tid sequence 0,1,0 exactly; no drop or duplicate.
- Assert areset_n low with 3 queued tokens -> all tvalid=0 immediately; after release, queues empty and wr_req_ready=1.

Source files
------------

// File: rtl/logic_axi4_lite_bus_pkg.sv
// Shared types and address decode for the AXI4-Lite bus route scheduler.
// Tables are widened to fixed maxima so the decode function stays parameter-free.
package logic_axi4_lite_bus_pkg;

  localparam int MAX_SLAVES = 16;
  localparam int MAX_ADDR_W = 64;
  localparam int MAX_TID_W  = 4;

  typedef logic [MAX_SLAVES-1:0][MAX_ADDR_W-1:0] addr_table_t;

  typedef struct packed {
    logic                 hit;
    logic [MAX_TID_W-1:0] tid;
  } route_token_t;

  // Scans from the top down so the lowest matching slave overwrites the result.
  function automatic route_token_t route_decode(input logic [MAX_ADDR_W-1:0] addr,
                                                input addr_table_t base,
                                                input addr_table_t mask,
                                                input int n_slaves);
    route_token_t tok;
    tok = '0;
    for (int k = MAX_SLAVES - 1; k >= 0; k--) begin
      if ((k < n_slaves) && ((addr & mask[k]) == (base[k] & mask[k]))) begin
        tok.hit = 1'b1;
        tok.tid = MAX_TID_W'(k);
      end
    end
    return tok;
  endfunction

endpackage

// File: rtl/logic_axi4_lite_bus_route_fifo.sv
// In-order route token FIFO with wrap-bit pointers; push and pop may coincide when full.
module logic_axi4_lite_bus_route_fifo #(
  parameter int DEPTH   = 4,
  parameter int TOKEN_W = 2
) (
  input  logic               aclk,
  input  logic               areset_n,
  input  logic               i_push,
  input  logic [TOKEN_W-1:0] i_push_data,
  input  logic               i_pop,
  output logic               o_full,
  output logic               o_empty,
  output logic [TOKEN_W-1:0] o_head
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [TOKEN_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                     (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr[IDX_W-1:0]];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/logic_axi4_lite_bus_route_scheduler.sv
// Route token scheduler for a multi-slave AXI4-Lite mux (AW/W/B and AR/R tokens).
// Optional decode-error counters: LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN.
module logic_axi4_lite_bus_route_scheduler
  import logic_axi4_lite_bus_pkg::*;
#(
  parameter int SLAVES        = 1,
  parameter int SLAVES_WIDTH  = (SLAVES >= 2) ? $clog2(SLAVES) : 1,
  parameter int ADDRESS_WIDTH = 32,
  parameter int OUTSTANDING   = 4,
  parameter logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     wr_req_valid,
  output logic                     wr_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_req_addr,
  input  logic                     rd_req_valid,
  output logic                     rd_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] rd_req_addr,
  output logic                     aw_tvalid,
  input  logic                     aw_tready,
  output logic [SLAVES_WIDTH-1:0]  aw_tid,
  output logic                     aw_thit,
  output logic                     w_tvalid,
  input  logic                     w_tready,
  output logic [SLAVES_WIDTH-1:0]  w_tid,
  output logic                     w_thit,
  output logic                     b_tvalid,
  input  logic                     b_tready,
  output logic [SLAVES_WIDTH-1:0]  b_tid,
  output logic                     b_thit,
  output logic                     ar_tvalid,
  input  logic                     ar_tready,
  output logic [SLAVES_WIDTH-1:0]  ar_tid,
  output logic                     ar_thit,
  output logic                     r_tvalid,
  input  logic                     r_tready,
  output logic [SLAVES_WIDTH-1:0]  r_tid,
  output logic                     r_thit
`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
  ,
  output logic [15:0]              decerr_wr_count,
  output logic [15:0]              decerr_rd_count
`endif
);

  localparam int TOK_W = SLAVES_WIDTH + 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  function automatic addr_table_t widen_table(input logic [SLAVES-1:0][ADDRESS_WIDTH-1:0] t);
    addr_table_t wt;
    wt = '0;
    for (int k = 0; k < SLAVES; k++) wt[k] = MAX_ADDR_W'(t[k]);
    return wt;
  endfunction

  localparam addr_table_t BASE_TBL = widen_table(SLAVE_BASE);
  localparam addr_table_t MASK_TBL = widen_table(SLAVE_MASK);

  route_token_t     w_wr_dec, w_rd_dec;
  logic [TOK_W-1:0] w_wr_tok, w_rd_tok;
  logic             w_unused_tid;
  logic             w_wr_fire, w_rd_fire;
  logic             w_w_pop, w_b_pop, w_r_pop;
  logic             w_wq_full, w_wq_empty, w_bq_full, w_bq_empty, w_rq_full, w_rq_empty;
  logic [TOK_W-1:0] w_wq_head, w_bq_head, w_rq_head;
  logic             r_aw_valid, r_ar_valid;
  logic [TOK_W-1:0] r_aw_tok, r_ar_tok;
  logic [CNT_W-1:0] r_done;

  assign w_wr_dec     = route_decode(MAX_ADDR_W'(wr_req_addr), BASE_TBL, MASK_TBL, SLAVES);
  assign w_rd_dec     = route_decode(MAX_ADDR_W'(rd_req_addr), BASE_TBL, MASK_TBL, SLAVES);
  assign w_wr_tok     = {w_wr_dec.hit, w_wr_dec.tid[SLAVES_WIDTH-1:0]};
  assign w_rd_tok     = {w_rd_dec.hit, w_rd_dec.tid[SLAVES_WIDTH-1:0]};
  assign w_unused_tid = ^{w_wr_dec.tid, w_rd_dec.tid};

  assign wr_req_ready = (!r_aw_valid || aw_tready) && !w_wq_full && !w_bq_full;
  assign rd_req_ready = (!r_ar_valid || ar_tready) && !w_rq_full;
  assign w_wr_fire    = wr_req_valid && wr_req_ready;
  assign w_rd_fire    = rd_req_valid && rd_req_ready;

  // A B token is only offered once its W token has already left the W queue.
  assign w_tvalid = !w_wq_empty;
  assign b_tvalid = !w_bq_empty && (r_done != '0);
  assign r_tvalid = !w_rq_empty;
  assign w_w_pop  = w_tvalid && w_tready;
  assign w_b_pop  = b_tvalid && b_tready;
  assign w_r_pop  = r_tvalid && r_tready;

  assign aw_tvalid         = r_aw_valid;
  assign ar_tvalid         = r_ar_valid;
  assign {aw_thit, aw_tid} = r_aw_tok;
  assign {ar_thit, ar_tid} = r_ar_tok;
  assign {w_thit, w_tid}   = w_wq_head;
  assign {b_thit, b_tid}   = w_bq_head;
  assign {r_thit, r_tid}   = w_rq_head;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_aw_valid <= 1'b0;
      r_aw_tok   <= '0;
      r_ar_valid <= 1'b0;
      r_ar_tok   <= '0;
      r_done     <= '0;
    end else begin
      if (w_wr_fire) begin
        r_aw_valid <= 1'b1;
        r_aw_tok   <= w_wr_tok;
      end else if (aw_tready) begin
        r_aw_valid <= 1'b0;
      end
      if (w_rd_fire) begin
        r_ar_valid <= 1'b1;
        r_ar_tok   <= w_rd_tok;
      end else if (ar_tready) begin
        r_ar_valid <= 1'b0;
      end
      if (w_w_pop && !w_b_pop)      r_done <= r_done + CNT_W'(1);
      else if (!w_w_pop && w_b_pop) r_done <= r_done - CNT_W'(1);
    end
  end

  logic_axi4_lite_bus_route_fifo #(.DEPTH(OUTSTANDING), .TOKEN_W(TOK_W)) u_w_fifo (
    .aclk(aclk), .areset_n(areset_n), .i_push(w_wr_fire), .i_push_data(w_wr_tok),
    .i_pop(w_w_pop), .o_full(w_wq_full), .o_empty(w_wq_empty), .o_head(w_wq_head)
  );

  logic_axi4_lite_bus_route_fifo #(.DEPTH(OUTSTANDING), .TOKEN_W(TOK_W)) u_b_fifo (
    .aclk(aclk), .areset_n(areset_n), .i_push(w_wr_fire), .i_push_data(w_wr_tok),
    .i_pop(w_b_pop), .o_full(w_bq_full), .o_empty(w_bq_empty), .o_head(w_bq_head)
  );

  logic_axi4_lite_bus_route_fifo #(.DEPTH(OUTSTANDING), .TOKEN_W(TOK_W)) u_r_fifo (
    .aclk(aclk), .areset_n(areset_n), .i_push(w_rd_fire), .i_push_data(w_rd_tok),
    .i_pop(w_r_pop), .o_full(w_rq_full), .o_empty(w_rq_empty), .o_head(w_rq_head)
  );

`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
  logic [15:0] r_decerr_wr, r_decerr_rd;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_decerr_wr <= '0;
      r_decerr_rd <= '0;
    end else begin
      if (w_wr_fire && !w_wr_dec.hit && (r_decerr_wr != 16'hFFFF)) r_decerr_wr <= r_decerr_wr + 16'd1;
      if (w_rd_fire && !w_rd_dec.hit && (r_decerr_rd != 16'hFFFF)) r_decerr_rd <= r_decerr_rd + 16'd1;
    end
  end

  assign decerr_wr_count = r_decerr_wr;
  assign decerr_rd_count = r_decerr_rd;
`endif

endmodule

// File: tb/tb_logic_axi4_lite_bus_route_scheduler.sv
// Bench for the route scheduler: queue-based reference model plus directed scenarios.
module tb_logic_axi4_lite_bus_route_scheduler;

  localparam int OUT = 4;
  localparam logic [1:0][31:0] BASE = {32'h0000_1000, 32'h0000_0000};
  localparam logic [1:0][31:0] MASK = {32'h0000_F000, 32'h0000_F000};

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        wr_req_valid, wr_req_ready, rd_req_valid, rd_req_ready;
  logic [31:0] wr_req_addr, rd_req_addr;
  logic        aw_tvalid, aw_tready, aw_tid, aw_thit;
  logic        w_tvalid, w_tready, w_tid, w_thit;
  logic        b_tvalid, b_tready, b_tid, b_thit;
  logic        ar_tvalid, ar_tready, ar_tid, ar_thit;
  logic        r_tvalid, r_tready, r_tid, r_thit;
`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
  logic [15:0] decerr_wr_count, decerr_rd_count;
`endif

  always #5 aclk = ~aclk;

  logic_axi4_lite_bus_route_scheduler #(
    .SLAVES(2), .ADDRESS_WIDTH(32), .OUTSTANDING(OUT), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_req_addr(wr_req_addr),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .aw_tvalid(aw_tvalid), .aw_tready(aw_tready), .aw_tid(aw_tid), .aw_thit(aw_thit),
    .w_tvalid(w_tvalid), .w_tready(w_tready), .w_tid(w_tid), .w_thit(w_thit),
    .b_tvalid(b_tvalid), .b_tready(b_tready), .b_tid(b_tid), .b_thit(b_thit),
    .ar_tvalid(ar_tvalid), .ar_tready(ar_tready), .ar_tid(ar_tid), .ar_thit(ar_thit),
    .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tid(r_tid), .r_thit(r_thit)
`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
    , .decerr_wr_count(decerr_wr_count), .decerr_rd_count(decerr_rd_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: tokens encoded as hit*2 + tid.
  bit m_aw_v, m_ar_v;
  int m_aw_tok, m_ar_tok;
  int wq[$], bq[$], rq[$];
  int m_dec_wr, m_dec_rd;
  bit cap_en;
  int r_log[$];

  function automatic int mdec(input logic [31:0] a);
    int nib;
    nib = int'((a >> 12) & 32'hF);
    if (nib == 0) return 2;
    if (nib == 1) return 3;
    return 0;
  endfunction

  function automatic bit m_wr_ready();
    return (!m_aw_v || aw_tready) && (wq.size() < OUT) && (bq.size() < OUT);
  endfunction

  function automatic bit m_rd_ready();
    return (!m_ar_v || ar_tready) && (rq.size() < OUT);
  endfunction

  // Every B entry whose W partner has already gone is eligible.
  function automatic bit m_b_valid();
    return bq.size() > wq.size();
  endfunction

  task automatic model_clear();
    m_aw_v = 0; m_ar_v = 0; m_aw_tok = 0; m_ar_tok = 0;
    wq.delete(); bq.delete(); rq.delete();
    m_dec_wr = 0; m_dec_rd = 0;
  endtask

  task automatic model_update();
    bit fw, fr, wp, bp, rp;
    int tw, tr;
    if (!areset_n) begin
      model_clear();
      return;
    end
    fw = wr_req_valid && m_wr_ready();
    fr = rd_req_valid && m_rd_ready();
    wp = (wq.size() > 0) && w_tready;
    bp = m_b_valid() && b_tready;
    rp = (rq.size() > 0) && r_tready;
    tw = mdec(wr_req_addr);
    tr = mdec(rd_req_addr);
    if (fw) begin m_aw_v = 1; m_aw_tok = tw; end
    else if (aw_tready) m_aw_v = 0;
    if (fr) begin m_ar_v = 1; m_ar_tok = tr; end
    else if (ar_tready) m_ar_v = 0;
    if (wp) void'(wq.pop_front());
    if (bp) void'(bq.pop_front());
    if (rp) void'(rq.pop_front());
    if (fw) begin
      wq.push_back(tw); bq.push_back(tw);
      if (tw < 2 && m_dec_wr < 65535) m_dec_wr++;
    end
    if (fr) begin
      rq.push_back(tr);
      if (tr < 2 && m_dec_rd < 65535) m_dec_rd++;
    end
  endtask

  task automatic check_all();
    chk("wr_req_ready", 32'(wr_req_ready), 32'(m_wr_ready()));
    chk("rd_req_ready", 32'(rd_req_ready), 32'(m_rd_ready()));
    chk("aw_tvalid", 32'(aw_tvalid), 32'(m_aw_v));
    if (m_aw_v) chk("aw_token", 32'({aw_thit, aw_tid}), 32'(m_aw_tok));
    chk("ar_tvalid", 32'(ar_tvalid), 32'(m_ar_v));
    if (m_ar_v) chk("ar_token", 32'({ar_thit, ar_tid}), 32'(m_ar_tok));
    chk("w_tvalid", 32'(w_tvalid), 32'(wq.size() > 0));
    if (wq.size() > 0) chk("w_token", 32'({w_thit, w_tid}), 32'(wq[0]));
    chk("b_tvalid", 32'(b_tvalid), 32'(m_b_valid()));
    if (m_b_valid()) chk("b_token", 32'({b_thit, b_tid}), 32'(bq[0]));
    chk("r_tvalid", 32'(r_tvalid), 32'(rq.size() > 0));
    if (rq.size() > 0) chk("r_token", 32'({r_thit, r_tid}), 32'(rq[0]));
`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
    chk("decerr_wr_count", 32'(decerr_wr_count), 32'(m_dec_wr));
    chk("decerr_rd_count", 32'(decerr_rd_count), 32'(m_dec_rd));
`endif
  endtask

  task automatic cycle();
    @(negedge aclk);
    check_all();
    if (cap_en && r_tvalid && r_tready) r_log.push_back(int'(r_tid));
    @(posedge aclk);
    model_update();
    #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    logic [3:0]  nib;
    a   = $urandom;
    nib = 4'($urandom_range(0, 3));
    a[15:12] = nib;
    return a;
  endfunction

  task automatic set_readies(input bit aw, input bit w, input bit b, input bit ar, input bit r);
    aw_tready = aw; w_tready = w; b_tready = b; ar_tready = ar; r_tready = r;
  endtask

  initial begin
    logic [31:0] rd_addrs [3];
    bit acc;
    areset_n = 1'b0;
    wr_req_valid = 0; rd_req_valid = 0; wr_req_addr = '0; rd_req_addr = '0;
    set_readies(0, 0, 0, 0, 0);
    cap_en = 0;
    model_clear();
    repeat (3) cycle();
    chk("reset_wr_ready", 32'(wr_req_ready), 32'd1);
    chk("reset_rd_ready", 32'(rd_req_ready), 32'd1);
    chk("reset_tids", 32'({aw_tid, w_tid, b_tid, ar_tid, r_tid}), 32'd0);
    chk("reset_thits", 32'({aw_thit, w_thit, b_thit, ar_thit, r_thit}), 32'd0);
    areset_n = 1'b1;
    cycle();

    // Write to slave 1; B must wait for the W pop even with b_tready high.
    wr_req_addr = 32'h0000_1004; wr_req_valid = 1;
    cycle();
    wr_req_valid = 0;
    #1;
    chk("aw_first_valid", 32'(aw_tvalid), 32'd1);
    chk("aw_first_tid", 32'(aw_tid), 32'd1);
    chk("aw_first_hit", 32'(aw_thit), 32'd1);
    chk("w_first_tid", 32'(w_tid), 32'd1);
    set_readies(1, 0, 1, 0, 0);
    repeat (3) begin
      cycle();
      chk("b_blocked_by_w", 32'(b_tvalid), 32'd0);
    end
    w_tready = 1;
    cycle();
    w_tready = 0;
    #1;
    chk("b_after_w_valid", 32'(b_tvalid), 32'd1);
    chk("b_after_w_tid", 32'(b_tid), 32'd1);
    cycle();
    chk("b_drained", 32'(b_tvalid), 32'd0);

    // Decode miss.
    wr_req_addr = 32'h0000_8000; wr_req_valid = 1;
    cycle();
    wr_req_valid = 0;
    #1;
    chk("miss_aw_hit", 32'(aw_thit), 32'd0);
    chk("miss_aw_tid", 32'(aw_tid), 32'd0);
    chk("miss_w_hit", 32'(w_thit), 32'd0);
    set_readies(1, 1, 1, 0, 0);
    repeat (4) cycle();
`ifdef LOGIC_AXI4_LITE_BUS_ROUTE_SCHEDULER_STATS_EN
    chk("decerr_after_miss", 32'(decerr_wr_count), 32'd1);
`endif

    // Fill the write queues, then release W and B one at a time.
    set_readies(1, 0, 0, 0, 0);
    for (int i = 0; i < OUT; i++) begin
      wr_req_addr = 32'h0000_1000 - 32'(i * 16) * 32'(i % 2); wr_req_valid = 1;
      cycle();
    end
    wr_req_valid = 0;
    #1;
    chk("full_wr_ready", 32'(wr_req_ready), 32'd0);
    w_tready = 1;
    cycle();
    w_tready = 0;
    #1;
    chk("w_pop_b_full_ready", 32'(wr_req_ready), 32'd0);
    chk("b_valid_after_w_pop", 32'(b_tvalid), 32'd1);
    b_tready = 1;
    cycle();
    b_tready = 0;
    #1;
    chk("ready_after_b_pop", 32'(wr_req_ready), 32'd1);
    set_readies(1, 1, 1, 1, 1);
    repeat (8) cycle();

    // Reads to slaves 0,1,0 with random r_tready: exact in-order token sequence.
    rd_addrs[0] = 32'h0000_0000; rd_addrs[1] = 32'h0000_1000; rd_addrs[2] = 32'h0000_0010;
    cap_en = 1;
    r_log.delete();
    for (int i = 0; i < 3; i++) begin
      rd_req_addr = rd_addrs[i]; rd_req_valid = 1;
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        ar_tready = 1'($urandom_range(0, 1));
        r_tready  = 1'($urandom_range(0, 1));
        acc = m_rd_ready();
        cycle();
      end
      if (!acc) chk("rd_accept_timeout", 32'd0, 32'd1);
    end
    rd_req_valid = 0;
    for (int t = 0; t < 40 && r_log.size() < 3; t++) begin
      ar_tready = 1; r_tready = 1'($urandom_range(0, 1));
      cycle();
    end
    cap_en = 0;
    chk("r_seq_len", 32'(r_log.size()), 32'd3);
    if (r_log.size() == 3) begin
      chk("r_seq_0", 32'(r_log[0]), 32'd0);
      chk("r_seq_1", 32'(r_log[1]), 32'd1);
      chk("r_seq_2", 32'(r_log[2]), 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      wr_req_valid = 1'($urandom_range(0, 1));
      rd_req_valid = 1'($urandom_range(0, 1));
      wr_req_addr  = rnd_addr();
      rd_req_addr  = rnd_addr();
      set_readies(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0));
      cycle();
    end
    wr_req_valid = 0; rd_req_valid = 0;

    // Reset with queued tokens.
    set_readies(1, 0, 0, 0, 0);
    repeat (8) cycle();
    for (int i = 0; i < 3; i++) begin
      wr_req_addr = 32'h0000_1000; wr_req_valid = 1;
      cycle();
    end
    wr_req_valid = 0;
    set_readies(0, 0, 0, 0, 0);
    #1;
    chk("pre_reset_w_valid", 32'(w_tvalid), 32'd1);
    areset_n = 1'b0;
    #1;
    model_clear();
    chk("async_reset_valids", 32'({aw_tvalid, w_tvalid, b_tvalid, ar_tvalid, r_tvalid}), 32'd0);
    chk("async_reset_wr_ready", 32'(wr_req_ready), 32'd1);
    repeat (2) cycle();
    areset_n = 1'b1;
    repeat (3) cycle();
    chk("post_reset_w_valid", 32'(w_tvalid), 32'd0);
    chk("post_reset_b_valid", 32'(b_tvalid), 32'd0);
    chk("post_reset_wr_ready", 32'(wr_req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
